// File: rtl/processor.sv
// processor_pkg
//   Shared controller state type. The numeric state values are part of the
//   visible interface (the controller's `state` register is probed by value).
package processor_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXEC      = 3'd2,
    WRITEBACK = 3'd3,
    LOADI     = 3'd4
  } state_t;

  localparam logic [5:0] OP_AND = 6'd6;
  localparam logic [5:0] OP_OR  = 6'd7;
  localparam logic [5:0] OP_XOR = 6'd8;
  localparam logic [5:0] OP_NOT = 6'd9;
  localparam logic [5:0] OP_LI  = 6'd10;

endpackage

// register
//   One 32-bit general register. Not reset: it powers up undefined and keeps
//   its contents across a controller reset.
//   clk  : clock
//   we   : write enable, sampled on the rising edge
//   d    : write data
//   q    : current contents
module register (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] internal;

  always_ff @(posedge clk) begin
    if (we) internal <= d;
  end

  assign q = internal;

endmodule

// controller
//   Multi-cycle sequencing FSM. Chooses the next state from the opcode on the
//   instruction bus while in FETCH and from the latched IR opcode afterwards.
//   clk      : clock
//   reset    : asynchronous, active-low
//   op_fetch : opcode currently on the instruction input
//   op_ir    : opcode held in IR
//   state_o  : current state
//   to_fetch : combinational, high on the cycle whose edge returns to FETCH
//   sys_dne  : registered one-cycle completion pulse
module controller
  import processor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_fetch,
  input  logic [5:0] op_ir,
  output state_t     state_o,
  output logic       to_fetch,
  output logic       sys_dne
);

  state_t state;
  state_t state_d;

  always_comb begin
    state_d  = state;
    to_fetch = 1'b0;
    case (state)
      FETCH: begin
        if (op_fetch == OP_LI)       state_d = LOADI;
        else if (op_fetch == OP_NOT) state_d = EXEC;
        else                         state_d = DECODE;
      end
      DECODE: begin
        if (op_ir == OP_AND || op_ir == OP_OR || op_ir == OP_XOR) begin
          state_d = EXEC;
        end else begin
          state_d  = FETCH;
          to_fetch = 1'b1;
        end
      end
      EXEC:      state_d = WRITEBACK;
      WRITEBACK: begin
        state_d  = FETCH;
        to_fetch = 1'b1;
      end
      LOADI: begin
        state_d  = FETCH;
        to_fetch = 1'b1;
      end
      default: begin
        state_d  = FETCH;
        to_fetch = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      sys_dne <= 1'b0;
    end else begin
      state   <= state_d;
      sys_dne <= to_fetch;
    end
  end

  assign state_o = state;

endmodule

// processor
//   Multi-cycle 32-bit core: 32 general registers (r0..r31), controller `c`
//   and a bitwise logic ALU. Executes LI, AND, OR, XOR and NOT; any other
//   opcode is a NOP.
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low
//   instruction : instruction word, sampled on the edge leaving FETCH
//   addr        : program counter / instruction address
//   out         : data most recently written to the register file
//   sys_dne     : one-cycle pulse on instruction completion
//   rw          : memory direction, always 0 (read)
module processor
  import processor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [31:0] addr,
  output logic [31:0] out,
  output logic        sys_dne,
  output logic        rw
);

  state_t      state;
  logic        to_fetch;

  logic [31:0] ir_q,  ir_d;
  logic [31:0] a_q,   a_d;
  logic [31:0] b_q,   b_d;
  logic [31:0] z_q,   z_d;
  logic [31:0] pc_q,  pc_d;
  logic [31:0] out_q, out_d;
  logic        rw_q;

  logic [31:0] we;
  logic [31:0] wdata;
  logic [31:0] rq [32];

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val;

  assign op  = ir_q[31:26];
  assign rs  = ir_q[25:21];
  assign rt  = ir_q[20:16];
  assign rd  = ir_q[15:11];
  assign imm = ir_q[15:0];

  assign rs_val = rq[rs];
  assign rt_val = rq[rt];

  controller c (
    .clk      (clk),
    .reset    (reset),
    .op_fetch (instruction[31:26]),
    .op_ir    (op),
    .state_o  (state),
    .to_fetch (to_fetch),
    .sys_dne  (sys_dne)
  );

  register r0  (.clk(clk), .we(we[0]),  .d(wdata), .q(rq[0]));
  register r1  (.clk(clk), .we(we[1]),  .d(wdata), .q(rq[1]));
  register r2  (.clk(clk), .we(we[2]),  .d(wdata), .q(rq[2]));
  register r3  (.clk(clk), .we(we[3]),  .d(wdata), .q(rq[3]));
  register r4  (.clk(clk), .we(we[4]),  .d(wdata), .q(rq[4]));
  register r5  (.clk(clk), .we(we[5]),  .d(wdata), .q(rq[5]));
  register r6  (.clk(clk), .we(we[6]),  .d(wdata), .q(rq[6]));
  register r7  (.clk(clk), .we(we[7]),  .d(wdata), .q(rq[7]));
  register r8  (.clk(clk), .we(we[8]),  .d(wdata), .q(rq[8]));
  register r9  (.clk(clk), .we(we[9]),  .d(wdata), .q(rq[9]));
  register r10 (.clk(clk), .we(we[10]), .d(wdata), .q(rq[10]));
  register r11 (.clk(clk), .we(we[11]), .d(wdata), .q(rq[11]));
  register r12 (.clk(clk), .we(we[12]), .d(wdata), .q(rq[12]));
  register r13 (.clk(clk), .we(we[13]), .d(wdata), .q(rq[13]));
  register r14 (.clk(clk), .we(we[14]), .d(wdata), .q(rq[14]));
  register r15 (.clk(clk), .we(we[15]), .d(wdata), .q(rq[15]));
  register r16 (.clk(clk), .we(we[16]), .d(wdata), .q(rq[16]));
  register r17 (.clk(clk), .we(we[17]), .d(wdata), .q(rq[17]));
  register r18 (.clk(clk), .we(we[18]), .d(wdata), .q(rq[18]));
  register r19 (.clk(clk), .we(we[19]), .d(wdata), .q(rq[19]));
  register r20 (.clk(clk), .we(we[20]), .d(wdata), .q(rq[20]));
  register r21 (.clk(clk), .we(we[21]), .d(wdata), .q(rq[21]));
  register r22 (.clk(clk), .we(we[22]), .d(wdata), .q(rq[22]));
  register r23 (.clk(clk), .we(we[23]), .d(wdata), .q(rq[23]));
  register r24 (.clk(clk), .we(we[24]), .d(wdata), .q(rq[24]));
  register r25 (.clk(clk), .we(we[25]), .d(wdata), .q(rq[25]));
  register r26 (.clk(clk), .we(we[26]), .d(wdata), .q(rq[26]));
  register r27 (.clk(clk), .we(we[27]), .d(wdata), .q(rq[27]));
  register r28 (.clk(clk), .we(we[28]), .d(wdata), .q(rq[28]));
  register r29 (.clk(clk), .we(we[29]), .d(wdata), .q(rq[29]));
  register r30 (.clk(clk), .we(we[30]), .d(wdata), .q(rq[30]));
  register r31 (.clk(clk), .we(we[31]), .d(wdata), .q(rq[31]));

  // Write enables are decoded from the current state, so an asynchronous
  // reset (which forces FETCH) suppresses any pending register write.
  always_comb begin
    ir_d  = ir_q;
    a_d   = a_q;
    b_d   = b_q;
    z_d   = z_q;
    out_d = out_q;
    pc_d  = pc_q;
    we    = '0;
    wdata = z_q;

    case (state)
      FETCH:  ir_d = instruction;
      DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
      end
      EXEC: begin
        case (op)
          OP_AND:  z_d = a_q & b_q;
          OP_OR:   z_d = a_q | b_q;
          OP_XOR:  z_d = a_q ^ b_q;
          // NOT skips DECODE, so its operand comes straight from the file.
          OP_NOT:  z_d = ~rs_val;
          default: z_d = z_q;
        endcase
      end
      WRITEBACK: begin
        wdata = z_q;
        out_d = z_q;
        if (op == OP_NOT) we[rt] = 1'b1;
        else              we[rd] = 1'b1;
      end
      LOADI: begin
        wdata  = {16'h0000, imm};
        out_d  = {16'h0000, imm};
        we[rs] = 1'b1;
      end
      default: ;
    endcase

    if (to_fetch) pc_d = pc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      z_q   <= '0;
      pc_q  <= '0;
      out_q <= '0;
      rw_q  <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      z_q   <= z_d;
      pc_q  <= pc_d;
      out_q <= out_d;
      rw_q  <= 1'b0;
    end
  end

  assign addr = pc_q;
  assign out  = out_q;
  assign rw   = rw_q;

endmodule

// File: tb/tb_processor.sv
module tb_processor;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] addr;
  logic [31:0] out;
  logic        sys_dne;
  logic        rw;

  int unsigned total;
  int unsigned bad;

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] m_out;

  logic [31:0] rf_dut [32];

  processor dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .addr        (addr),
    .out         (out),
    .sys_dne     (sys_dne),
    .rw          (rw)
  );

  assign rf_dut[0]  = dut.r0.internal;   assign rf_dut[1]  = dut.r1.internal;
  assign rf_dut[2]  = dut.r2.internal;   assign rf_dut[3]  = dut.r3.internal;
  assign rf_dut[4]  = dut.r4.internal;   assign rf_dut[5]  = dut.r5.internal;
  assign rf_dut[6]  = dut.r6.internal;   assign rf_dut[7]  = dut.r7.internal;
  assign rf_dut[8]  = dut.r8.internal;   assign rf_dut[9]  = dut.r9.internal;
  assign rf_dut[10] = dut.r10.internal;  assign rf_dut[11] = dut.r11.internal;
  assign rf_dut[12] = dut.r12.internal;  assign rf_dut[13] = dut.r13.internal;
  assign rf_dut[14] = dut.r14.internal;  assign rf_dut[15] = dut.r15.internal;
  assign rf_dut[16] = dut.r16.internal;  assign rf_dut[17] = dut.r17.internal;
  assign rf_dut[18] = dut.r18.internal;  assign rf_dut[19] = dut.r19.internal;
  assign rf_dut[20] = dut.r20.internal;  assign rf_dut[21] = dut.r21.internal;
  assign rf_dut[22] = dut.r22.internal;  assign rf_dut[23] = dut.r23.internal;
  assign rf_dut[24] = dut.r24.internal;  assign rf_dut[25] = dut.r25.internal;
  assign rf_dut[26] = dut.r26.internal;  assign rf_dut[27] = dut.r27.internal;
  assign rf_dut[28] = dut.r28.internal;  assign rf_dut[29] = dut.r29.internal;
  assign rf_dut[30] = dut.r30.internal;  assign rf_dut[31] = dut.r31.internal;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  // Executes one instruction through the DUT and the model, checking
  // latency, completion state, out/addr and the written register.
  task automatic run_instr(input logic [31:0] instr);
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] val;
    int          dest;
    int          lat;
    int          n;
    bit          done;

    op   = instr[31:26];
    rs   = instr[25:21];
    rt   = instr[20:16];
    rd   = instr[15:11];
    dest = -1;
    val  = '0;
    case (op)
      6'd10: begin lat = 2; dest = rs; val = {16'h0000, instr[15:0]}; end
      6'd6:  begin lat = 4; dest = rd; val = m_regs[rs] & m_regs[rt]; end
      6'd7:  begin lat = 4; dest = rd; val = m_regs[rs] | m_regs[rt]; end
      6'd8:  begin lat = 4; dest = rd; val = m_regs[rs] ^ m_regs[rt]; end
      6'd9:  begin lat = 3; dest = rt; val = ~m_regs[rs]; end
      default: lat = 2;
    endcase

    instruction = instr;
    n    = 0;
    done = 1'b0;
    while (!done && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) instruction = $urandom;
      if (sys_dne) done = 1'b1;
      if (rw !== 1'b0) check("rw", {31'd0, rw}, 32'd0);
    end
    check("latency", n, lat);

    m_pc = m_pc + 32'd1;
    if (dest >= 0) begin
      m_regs[dest] = val;
      m_out        = val;
    end
    check("addr", addr, m_pc);
    check("out", out, m_out);
    check("state", 32'(dut.c.state), 32'd0);
    if (dest >= 0) check("regwrite", rf_dut[dest], m_regs[dest]);
  endtask

  function automatic logic [31:0] rand_other_op(input logic [31:0] r);
    logic [5:0]  op;
    logic [31:0] w;
    op = 6'(r % 59);
    if (op >= 6'd6) op = op + 6'd5;
    w = r;
    w[31:26] = op;
    return w;
  endfunction

  initial begin
    logic [31:0] seq [6];
    logic [31:0] w;
    logic [31:0] kept;
    int unsigned sel;

    total = 0;
    bad   = 0;
    m_pc  = '0;
    m_out = '0;
    for (int unsigned i = 0; i < 32; i++) m_regs[i] = 'x;

    reset       = 1'b0;
    instruction = '0;
    #12;
    check("rst_addr", addr, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_dne", {31'd0, sys_dne}, 32'd0);
    check("rst_rw", {31'd0, rw}, 32'd0);
    check("rst_state", 32'(dut.c.state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // No valid instruction: behaves as a NOP.
    run_instr(32'h0000_0000);

    seq[0] = 32'h2960731A;
    seq[1] = 32'h29802250;
    seq[2] = 32'h196C2800;
    seq[3] = 32'h1D6CA800;
    seq[4] = 32'h216C8800;
    seq[5] = 32'h257E0000;
    foreach (seq[i]) run_instr(seq[i]);

    check("r5",  rf_dut[5],  m_regs[5]);
    check("r11", rf_dut[11], m_regs[11]);
    check("r12", rf_dut[12], m_regs[12]);
    check("r17", rf_dut[17], m_regs[17]);
    check("r21", rf_dut[21], m_regs[21]);
    check("r30", rf_dut[30], 32'hFFFF8CE5);
    check("addr7", addr, 32'd7);

    // Reset in the middle of an AND that would overwrite r5.
    kept = m_regs[5];
    instruction = 32'h196C2800;
    @(posedge clk); #1;
    instruction = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    m_pc  = '0;
    m_out = '0;
    check("mid_state", 32'(dut.c.state), 32'd0);
    check("mid_addr", addr, 32'd0);
    check("mid_out", out, 32'd0);
    check("mid_dne", {31'd0, sys_dne}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("mid_r5", rf_dut[5], kept);

    // Give every register a known value, then random traffic.
    for (int unsigned i = 0; i < 32; i++) begin
      w = $urandom;
      w[31:26] = 6'd10;
      w[25:21] = 5'(i);
      run_instr(w);
    end

    for (int unsigned k = 0; k < 200; k++) begin
      w   = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: w[31:26] = 6'd6;
        1: w[31:26] = 6'd7;
        2: w[31:26] = 6'd8;
        3: w[31:26] = 6'd9;
        4: w[31:26] = 6'd10;
        default: w = rand_other_op(w);
      endcase
      run_instr(w);
    end

    for (int unsigned i = 0; i < 32; i++) check("final_reg", rf_dut[i], m_regs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
